banked_data_mem_ctrl: RTL and testbench
=======================================

// Module: banked_data_mem_ctrl
// PURPOSE
//  Parametrised successor to the multicycle data memory. Holds NBANKS byte-wide banks in little-endian order
//  (bank 0 = bits [7:0]) and adds a req/ack handshake with programmable wait states, byte-enable writes
//  and misaligned-address detection. The multicycle control FSM drives it; addr comes from alu_out,
//  wdata from B, and rdata feeds the mem_to_reg mux.
// PARAMETERS
//  DATA_W   16     word width in bits; multiple of 8; NBANKS = DATA_W/8
//  ADDR_W   16     byte-address width
//  DEPTH    32768  words per bank; index = addr[ADDR_W-1:log2(NBANKS)], taken modulo DEPTH
//  RD_WAIT  1      wait cycles before a read ack (0..15)
//  WR_WAIT  0      wait cycles before a write ack (0..15)
// PORTS
//  clk      in   1         rising-edge clock
//  rst_n    in   1         synchronous reset, active low
//  req      in   1         access request; sampled only in IDLE
//  we       in   1         1 = write, 0 = read; sampled with req
//  be       in   NBANKS    byte enables for writes; ignored on reads
//  addr     in   ADDR_W    byte address; must be word aligned
//  wdata    in   DATA_W    write data
//  rdata    out  DATA_W    read data; valid in the ack cycle, then held until the next read ack
//  ack      out  1         one-cycle completion pulse
//  busy     out  1         high in every non-IDLE state
//  err      out  1         one-cycle pulse, same cycle as ack, on a misaligned access
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state=IDLE; rdata=0, ack=0, busy=0, err=0; wait counter=0.
//   Array contents are not reset. Reset mid-access aborts it: no ack, and no write of a not-yet-committed
//   access.
//  States: IDLE -> WAIT -> RESP -> IDLE.
//  IDLE: when req=1, latch we/be/addr/wdata, load cnt = we ? WR_WAIT : RD_WAIT.
//   Go to WAIT if cnt!=0, else to RESP. busy rises the next cycle.
//  WAIT: cnt decrements each cycle; at cnt==1 go to RESP. Inputs are ignored (latched copies are used).
//  RESP (1 cycle): ack=1. If the latched addr[log2(NBANKS)-1:0] != 0, err=1, no array access and
//   rdata is unchanged.
//   Otherwise, read: rdata <= {bank[NB-1][idx],...,bank[0][idx]}.
//   Otherwise, write: bank[k][idx] <= wdata[8k+7:8k] for each k with be[k]=1; be=0 completes with no change.
//   Next state is always IDLE.
//  Latency (req sample edge to ack cycle): WAIT+1 cycles. Minimum 1 (WAIT=0), e.g. RD_WAIT=1 gives 2.
//  Back-to-back: req may stay high; a new request is sampled in the IDLE cycle after RESP, so throughput
//   is one access per WAIT+2 cycles.
//  A read after a write to the same word returns the new data (the write commits at the RESP edge).
//  Address wrap: idx beyond DEPTH-1 wraps modulo DEPTH; upper address bits beyond the index are ignored.
//  req while busy: ignored and not queued; the requester holds req until ack.
// STRUCTURE
//  Shared package mem_pkg: state encoding localparams (ST_IDLE=2'd0, ST_WAIT=2'd1, ST_RESP=2'd2),
//   and NBANKS/BANK_AW derivation helpers.
//  One sub-module: mem_bank (8-bit x DEPTH, sync write with enable, sync read), instantiated NBANKS
//   times in a generate loop. The FSM and wait counter stay in the top level.
// TESTING
//  1 Reset: rst_n=0 for 2 clks -> rdata=0, ack=0, busy=0, err=0; req held high during reset gives no ack.
//  2 Write 0xBEEF @0x0010 with be=2'b11, then read @0x0010 (RD_WAIT=1) -> read ack 2 cycles after req
//    sample, rdata=0xBEEF, err=0.
//  3 be=2'b01 write 0x12AB to 0x0010 holding 0xBEEF -> read returns 0xBEAB; be=2'b00 -> unchanged.
//  4 Read @0x0011 -> ack with err=1, rdata holds previous value, memory unchanged.
//  5 Assert rst_n=0 during WAIT of a write (WR_WAIT=3) -> no ack; later read shows the old data.
//  6 Back-to-back reads with req held high, RD_WAIT=0 -> ack every 2nd cycle, busy toggles accordingly;
//    address 0x0000 vs DEPTH*2 wrap yields the same word.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the banked data memory: FSM state encoding and
// bank-geometry helpers derived from the data width.
package mem_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    function automatic int nbanks(input int data_w);
        return data_w / 8;
    endfunction

    // Number of low byte-address bits that select a bank within a word.
    function automatic int bank_aw(input int data_w);
        return (data_w / 8 > 1) ? $clog2(data_w / 8) : 0;
    endfunction

endpackage

// File: rtl/mem_bank.sv
// One byte-wide memory bank: synchronous write with enable, synchronous read.
module mem_bank #(
    parameter int DEPTH = 32768,
    parameter int AW    = 15
) (
    input  logic          clk,
    input  logic          wen,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    q
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wen)
            mem[waddr] <= wdata;
        q <= mem[raddr];
    end

endmodule

// File: rtl/banked_data_mem_ctrl.sv
// Banked little-endian data memory with req/ack handshake, programmable
// read/write wait states, byte-enable writes and misalignment detection.
module banked_data_mem_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int DEPTH   = 32768,
    parameter int RD_WAIT = 1,
    parameter int WR_WAIT = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req,
    input  logic                      we,
    input  logic [DATA_W/8-1:0]       be,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [DATA_W-1:0]         wdata,
    output logic [DATA_W-1:0]         rdata,
    output logic                      ack,
    output logic                      busy,
    output logic                      err
);

    localparam int NBANKS  = nbanks(DATA_W);
    localparam int BANK_AW = bank_aw(DATA_W);
    localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] RD_CNT = 4'(RD_WAIT);
    localparam logic [3:0] WR_CNT = 4'(WR_WAIT);
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(NBANKS - 1);

    function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
        return IDX_W'((a >> BANK_AW) % DEPTH);
    endfunction

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic              lat_we;
    logic [NBANKS-1:0] lat_be;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] rdata_hold;
    logic [DATA_W-1:0] bank_q;
    logic [IDX_W-1:0]  lat_idx;
    logic [IDX_W-1:0]  raddr;
    logic [3:0]        load_cnt;
    logic              resp;
    logic              misalign;
    logic              rd_ok;
    logic              wr_ok;

    assign load_cnt = we ? WR_CNT : RD_CNT;
    assign lat_idx  = idx_of(lat_addr);
    assign misalign = (lat_addr & LOW_MASK) != '0;
    assign resp     = (state == ST_RESP);
    assign rd_ok    = resp && !lat_we && !misalign;
    assign wr_ok    = resp && lat_we && !misalign;

    // Banks read every cycle; in IDLE the live address is used so a
    // zero-wait access has its data ready in the RESP cycle.
    assign raddr = (state == ST_IDLE) ? idx_of(addr) : lat_idx;

    assign ack   = resp;
    assign err   = resp && misalign;
    assign busy  = (state != ST_IDLE);
    assign rdata = rd_ok ? bank_q : rdata_hold;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            rdata_hold <= '0;
        end else begin
            case (state)
                ST_IDLE: if (req) begin
                    cnt   <= load_cnt;
                    state <= (load_cnt != '0) ? ST_WAIT : ST_RESP;
                end
                ST_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1)
                        state <= ST_RESP;
                end
                ST_RESP: begin
                    if (rd_ok)
                        rdata_hold <= bank_q;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Request fields need no reset; they only matter once an access starts.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && req) begin
            lat_we    <= we;
            lat_be    <= be;
            lat_addr  <= addr;
            lat_wdata <= wdata;
        end
    end

    for (genvar k = 0; k < NBANKS; k++) begin : g_bank
        mem_bank #(.DEPTH(DEPTH), .AW(IDX_W)) u_bank (
            .clk   (clk),
            .wen   (wr_ok && lat_be[k]),
            .waddr (lat_idx),
            .wdata (lat_wdata[8*k +: 8]),
            .raddr (raddr),
            .q     (bank_q[8*k +: 8])
        );
    end

endmodule

// File: tb/tb_banked_data_mem_ctrl.sv
// Self-checking bench: two controllers (slow waits / zero waits) checked
// against a word-array reference model with random and directed traffic.
module tb_banked_data_mem_ctrl;

    localparam int DEPTH = 64;

    logic clk = 0;
    logic rst_n = 0;
    always #5 clk = ~clk;

    // DUT with RD_WAIT=1, WR_WAIT=3
    logic        req1 = 0, we1 = 0;
    logic [1:0]  be1 = 0;
    logic [15:0] addr1 = 0, wdata1 = 0, rdata1;
    logic        ack1, busy1, err1;

    // DUT with zero wait states
    logic        req0 = 0, we0 = 0;
    logic [1:0]  be0 = 0;
    logic [15:0] addr0 = 0, wdata0 = 0, rdata0;
    logic        ack0, busy0, err0;

    int errors = 0;
    int checks = 0;

    logic [15:0] m1 [DEPTH];
    logic [15:0] last_rd;

    banked_data_mem_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .RD_WAIT(1), .WR_WAIT(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .we(we1), .be(be1), .addr(addr1),
        .wdata(wdata1), .rdata(rdata1), .ack(ack1), .busy(busy1), .err(err1));

    banked_data_mem_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .RD_WAIT(0), .WR_WAIT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .we(we0), .be(be0), .addr(addr0),
        .wdata(wdata0), .rdata(rdata0), .ack(ack0), .busy(busy0), .err(err0));

    // One access on dut1; lat = number of clock edges from req sample to ack cycle.
    task automatic acc1(input logic w, input logic [1:0] b, input logic [15:0] a,
                        input logic [15:0] d, output int lat, output logic [15:0] rd,
                        output logic e);
        @(negedge clk);
        req1 = 1; we1 = w; be1 = b; addr1 = a; wdata1 = d;
        lat = 0;
        do begin
            @(posedge clk); lat++; @(negedge clk);
        end while (!ack1 && lat < 40);
        rd = rdata1; e = err1;
        req1 = 0;
    endtask

    task automatic acc0(input logic w, input logic [15:0] a, input logic [15:0] d, output int lat);
        @(negedge clk);
        req0 = 1; we0 = w; be0 = 2'b11; addr0 = a; wdata0 = d;
        lat = 0;
        do begin
            @(posedge clk); lat++; @(negedge clk);
        end while (!ack0 && lat < 40);
        req0 = 0;
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d, input logic [1:0] b);
        logic [15:0] r;
        r = old;
        if (b[0]) r[7:0]  = d[7:0];
        if (b[1]) r[15:8] = d[15:8];
        return r;
    endfunction

    task automatic test_reset;
        @(negedge clk);
        rst_n = 0; req1 = 1; we1 = 0; addr1 = 16'h0010;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if (ack1 !== 1'b0 || busy1 !== 1'b0 || err1 !== 1'b0 || rdata1 !== 16'h0) begin
                errors++;
                $display("FAIL reset: ack=%b busy=%b err=%b rdata=%h, want 0 0 0 0000", ack1, busy1, err1, rdata1);
            end
            checks++;
            if (ack0 !== 1'b0 || busy0 !== 1'b0 || rdata0 !== 16'h0) begin
                errors++;
                $display("FAIL reset_dut0: ack=%b busy=%b rdata=%h, want 0 0 0000", ack0, busy0, rdata0);
            end
        end
        req1 = 0;
        rst_n = 1;
        last_rd = 16'h0;
    endtask

    task automatic test_fill;
        int lat; logic [15:0] rd; logic e; logic [15:0] d;
        for (int i = 0; i < DEPTH; i++) begin
            d = 16'($urandom);
            acc1(1'b1, 2'b11, 16'(i * 2), d, lat, rd, e);
            m1[i] = d;
            checks++;
            if (lat !== 4 || e !== 1'b0) begin
                errors++;
                $display("FAIL fill_write[%0d]: lat=%0d err=%b, want 4 0", i, lat, e);
            end
        end
    endtask

    task automatic test_write_read;
        int lat; logic [15:0] rd; logic e;
        acc1(1'b1, 2'b11, 16'h0010, 16'hBEEF, lat, rd, e);
        m1[8] = 16'hBEEF;
        acc1(1'b0, 2'b00, 16'h0010, 16'h0000, lat, rd, e);
        last_rd = 16'hBEEF;
        checks++;
        if (lat !== 2 || rd !== 16'hBEEF || e !== 1'b0) begin
            errors++;
            $display("FAIL write_read: lat=%0d rdata=%h err=%b, want 2 beef 0", lat, rd, e);
        end
    endtask

    task automatic test_byte_enable;
        int lat; logic [15:0] rd; logic e;
        acc1(1'b1, 2'b01, 16'h0010, 16'h12AB, lat, rd, e);
        m1[8] = merge(m1[8], 16'h12AB, 2'b01);
        acc1(1'b0, 2'b00, 16'h0010, 16'h0, lat, rd, e);
        last_rd = rd;
        checks++;
        if (rd !== 16'hBEAB) begin
            errors++;
            $display("FAIL be_low: rdata=%h, want beab", rd);
        end
        acc1(1'b1, 2'b00, 16'h0010, 16'h5555, lat, rd, e);
        checks++;
        if (lat !== 4 || e !== 1'b0) begin
            errors++;
            $display("FAIL be_none_ack: lat=%0d err=%b, want 4 0", lat, e);
        end
        acc1(1'b0, 2'b00, 16'h0010, 16'h0, lat, rd, e);
        checks++;
        if (rd !== 16'hBEAB) begin
            errors++;
            $display("FAIL be_none: rdata=%h, want beab", rd);
        end
    endtask

    task automatic test_misaligned;
        int lat; logic [15:0] rd; logic e;
        acc1(1'b0, 2'b00, 16'h0011, 16'h0, lat, rd, e);
        checks++;
        if (lat !== 2 || e !== 1'b1 || rd !== 16'hBEAB) begin
            errors++;
            $display("FAIL misaligned_read: lat=%0d err=%b rdata=%h, want 2 1 beab", lat, e, rd);
        end
        acc1(1'b1, 2'b11, 16'h0013, 16'hDEAD, lat, rd, e);
        checks++;
        if (lat !== 4 || e !== 1'b1) begin
            errors++;
            $display("FAIL misaligned_write: lat=%0d err=%b, want 4 1", lat, e);
        end
        acc1(1'b0, 2'b00, 16'h0012, 16'h0, lat, rd, e);
        last_rd = rd;
        checks++;
        if (rd !== m1[9] || e !== 1'b0) begin
            errors++;
            $display("FAIL misaligned_nowrite: rdata=%h err=%b, want %h 0", rd, e, m1[9]);
        end
    endtask

    task automatic test_reset_mid_write;
        int lat; logic [15:0] rd; logic e; int seen;
        @(negedge clk);
        req1 = 1; we1 = 1; be1 = 2'b11; addr1 = 16'h0010; wdata1 = 16'h1234;
        @(posedge clk); @(negedge clk);
        req1 = 0;
        @(posedge clk); @(negedge clk);
        checks++;
        if (busy1 !== 1'b1) begin
            errors++;
            $display("FAIL mid_write_busy: busy=%b, want 1", busy1);
        end
        rst_n = 0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); @(negedge clk);
            if (i == 1) rst_n = 1;
            if (ack1) seen++;
        end
        checks++;
        if (seen != 0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL mid_write_abort: acks=%0d busy=%b, want 0 0", seen, busy1);
        end
        last_rd = 16'h0;
        acc1(1'b0, 2'b00, 16'h0010, 16'h0, lat, rd, e);
        last_rd = rd;
        checks++;
        if (rd !== 16'hBEAB) begin
            errors++;
            $display("FAIL mid_write_old: rdata=%h, want beab", rd);
        end
    endtask

    task automatic test_random;
        int lat; logic [15:0] rd; logic e;
        logic w; logic [1:0] b; logic [15:0] a, d; int idx; logic mis;
        for (int n = 0; n < 60; n++) begin
            w = 1'($urandom);
            b = 2'($urandom);
            a = 16'($urandom);
            if ($urandom_range(3) != 0) a[0] = 1'b0;
            d = 16'($urandom);
            idx = (int'(a) / 2) % DEPTH;
            mis = a[0];
            acc1(w, b, a, d, lat, rd, e);
            checks++;
            if (lat !== (w ? 4 : 2) || e !== mis) begin
                errors++;
                $display("FAIL rand_ack[%0d]: lat=%0d err=%b, want %0d %b", n, lat, e, w ? 4 : 2, mis);
            end
            if (!w) begin
                if (!mis) last_rd = m1[idx];
                checks++;
                if (rd !== last_rd) begin
                    errors++;
                    $display("FAIL rand_read[%0d] a=%h: rdata=%h, want %h", n, a, rd, last_rd);
                end
            end else if (!mis) begin
                m1[idx] = merge(m1[idx], d, b);
            end
        end
    endtask

    task automatic test_back_to_back;
        int lat; logic [15:0] w0, w1, exp;
        logic want;
        w0 = 16'($urandom); w1 = 16'($urandom);
        if (w1 == w0) w1 = ~w0;
        acc0(1'b1, 16'h0000, w0, lat);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL b2b_write_lat: lat=%0d, want 1", lat);
        end
        acc0(1'b1, 16'h0002, w1, lat);
        @(negedge clk);
        req0 = 1; we0 = 0; addr0 = 16'h0000;
        exp = w0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); @(negedge clk);
            want = (i % 2 == 0);
            checks++;
            if (ack0 !== want || busy0 !== want) begin
                errors++;
                $display("FAIL b2b_pulse[%0d]: ack=%b busy=%b, want %b %b", i, ack0, busy0, want, want);
            end
            if (want) begin
                checks++;
                if (rdata0 !== exp) begin
                    errors++;
                    $display("FAIL b2b_data[%0d]: rdata=%h, want %h", i, rdata0, exp);
                end
            end
            if (i == 3) begin addr0 = 16'(DEPTH * 2); exp = w0; end
            if (i == 5) begin addr0 = 16'h0002; exp = w1; end
        end
        req0 = 0;
    endtask

    initial begin
        test_reset;
        test_fill;
        test_write_read;
        test_byte_enable;
        test_misaligned;
        test_reset_mid_write;
        test_random;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, want completion");
        $fatal(1, "timeout");
    end

endmodule
